// File: rtl/avst_cmd_rr_arbiter_pkg.sv
// Shared types and width helpers for the AVST command round-robin arbiter.
// The command struct uses the default widths; the RTL itself is width-generic.
package avst_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_W     = 18;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_OUTSTAND   = 8;

    function automatic int cmd_w(input int aw, input int dw);
        return aw + dw + 2;
    endfunction

    function automatic int id_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    localparam int CMD_W = cmd_w(DEF_ADDR_W, DEF_DATA_W);
    localparam int ID_W  = id_w(DEF_NUM_REQ);

    typedef struct packed {
        logic                  is_read;
        logic                  is_32bit;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] write_data;
    } t_avst_cmd;

endpackage

// File: rtl/avst_cmd_rr_arbiter_if.sv
// Requester-side command/response bundle and bridge-side command/response bundle.
// The slave modport is the arbiter's view.
interface avst_cmd_rr_arbiter_if
    import avst_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int AVMM_ADDR_WIDTH = DEF_ADDR_W,
    parameter int AVMM_DATA_WIDTH = DEF_DATA_W,
    parameter int MAX_OUTSTANDING = DEF_OUTSTAND
);
    localparam int CW = cmd_w(AVMM_ADDR_WIDTH, AVMM_DATA_WIDTH);
    localparam int PW = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQ*CW-1:0]      req_data;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [CW-1:0]              cmd_data;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [AVMM_DATA_WIDTH-1:0] rsp_data;
    logic                       rsp_valid;
    logic [AVMM_DATA_WIDTH-1:0] rd_data;
    logic [NUM_REQ-1:0]         rd_valid;
    logic [PW-1:0]              rd_pending;
    logic                       rsp_orphan;

    modport slave (
        input  req_data, req_valid, cmd_ready, rsp_data, rsp_valid,
        output req_ready, cmd_data, cmd_valid, rd_data, rd_valid,
        output rd_pending, rsp_orphan
    );

    modport master (
        output req_data, req_valid, cmd_ready, rsp_data, rsp_valid,
        input  req_ready, cmd_data, cmd_valid, rd_data, rd_valid,
        input  rd_pending, rsp_orphan
    );

endinterface

// File: rtl/avst_cmd_rr_arbiter_id_fifo.sv
// Requester-ID FIFO recording the issue order of outstanding reads.
// Power-of-2 depth, so pointers simply wrap.
module avst_arb_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_id,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avst_cmd_rr_arbiter.sv
// Round-robin arbiter sharing one AVST command channel between requesters,
// returning in-order read responses to the requester that issued each read.
module avst_cmd_rr_arbiter
    import avst_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int AVMM_ADDR_WIDTH = DEF_ADDR_W,
    parameter int AVMM_DATA_WIDTH = DEF_DATA_W,
    parameter int MAX_OUTSTANDING = DEF_OUTSTAND
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avst_cmd_rr_arbiter_if.slave  bus
);
    localparam int CW  = cmd_w(AVMM_ADDR_WIDTH, AVMM_DATA_WIDTH);
    localparam int IDW = id_w(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     head;
    logic [IDW:0]       cand;
    logic               found;
    logic [NUM_REQ-1:0] is_read;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               push;
    logic               pop;
    logic [PW-1:0]      count;
    logic               orphan;

    // Reads are masked while the ID FIFO is full; writes always compete.
    always_comb begin
        is_read  = '0;
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            is_read[i]  = bus.req_data[i*CW + CW - 1];
            eligible[i] = reset_n & bus.req_valid[i]
                        & (~is_read[i] | ~fifo_full);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
            if (!found && eligible[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        bus.cmd_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && winner == IDW'(i))
                bus.cmd_data = bus.req_data[i*CW +: CW];
        end
    end

    assign grant         = found ? (NUM_REQ'(1) << winner) : '0;
    assign bus.cmd_valid = found;
    assign bus.req_ready = grant & {NUM_REQ{bus.cmd_ready}};
    assign accept        = found & bus.cmd_ready;
    assign push          = accept & is_read[winner];
    assign pop           = reset_n & bus.rsp_valid & ~fifo_empty;

    assign bus.rd_data    = bus.rsp_data;
    assign bus.rd_valid   = pop ? (NUM_REQ'(1) << head) : '0;
    assign bus.rd_pending = count;
    assign bus.rsp_orphan = orphan;

    avst_arb_id_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTSTANDING),
        .CW    (PW)
    ) u_id_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            orphan <= 1'b0;
        end else begin
            if (accept)
                rr_ptr <= (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
            if (bus.rsp_valid && fifo_empty)
                orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avst_cmd_rr_arbiter.sv
// Self-checking bench for avst_cmd_rr_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_avst_cmd_rr_arbiter;
    import avst_arb_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 18;
    localparam int DW   = 64;
    localparam int MAXO = 8;
    localparam int CW   = AW + DW + 2;
    localparam int PW   = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    avst_cmd_rr_arbiter_if #(
        .NUM_REQ(N), .AVMM_ADDR_WIDTH(AW),
        .AVMM_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) bus ();

    avst_cmd_rr_arbiter #(
        .NUM_REQ(N), .AVMM_ADDR_WIDTH(AW),
        .AVMM_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    t_avst_cmd m_cmd [N];
    int        m_ptr;
    int        m_q [$];
    bit        m_orphan;

    bit           e_valid;
    int           e_win;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rdv;
    logic [CW-1:0] e_data;

    function automatic void model_eval();
        int i;
        e_valid = 0;
        e_win   = 0;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (!e_valid && reset_n && bus.req_valid[i] &&
                (!m_cmd[i].is_read || m_q.size() < MAXO)) begin
                e_valid = 1;
                e_win   = i;
            end
        end
        e_data  = e_valid ? m_cmd[e_win] : '0;
        e_ready = (e_valid && bus.cmd_ready) ? N'(1) << e_win : '0;
        e_rdv   = (reset_n && bus.rsp_valid && m_q.size() > 0)
                ? N'(1) << m_q[0] : '0;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] rd,
                         input logic cr, input logic rv,
                         input logic [DW-1:0] rdat);
        logic [N*CW-1:0] d;
        for (int i = 0; i < N; i++) begin
            m_cmd[i].is_read    = rd[i];
            m_cmd[i].is_32bit   = 1'($urandom_range(0, 1));
            m_cmd[i].addr       = AW'($urandom);
            m_cmd[i].write_data = {$urandom, $urandom};
            d[i*CW +: CW]       = m_cmd[i];
        end
        bus.req_data  = d;
        bus.req_valid = v;
        bus.cmd_ready = cr;
        bus.rsp_valid = rv;
        bus.rsp_data  = rdat;
        model_eval();
        #1;
    endtask

    task automatic tick();
        bit pop;
        @(posedge clk);
        if (reset_n) begin
            pop = bus.rsp_valid && m_q.size() > 0;
            if (bus.rsp_valid && m_q.size() == 0) m_orphan = 1;
            if (e_valid && bus.cmd_ready) begin
                m_ptr = (e_win + 1) % N;
                if (m_cmd[e_win].is_read) m_q.push_back(e_win);
            end
            if (pop) void'(m_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_ptr = 0;
        m_q.delete();
        m_orphan = 0;
        drive('0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_q.delete();
        drive(4'b1111, 4'b0000, 1'b1, 1'b1, 64'h1234);
        n_checks++;
        if (bus.cmd_valid !== 1'b0)
            $display("FAIL reset_cmd_valid got %b want 0", bus.cmd_valid);
        else n_pass++;
        n_checks++;
        if (bus.req_ready !== 4'b0000)
            $display("FAIL reset_req_ready got %b want 0000", bus.req_ready);
        else n_pass++;
        n_checks++;
        if (bus.rd_valid !== 4'b0000)
            $display("FAIL reset_rd_valid got %b want 0000", bus.rd_valid);
        else n_pass++;
        n_checks++;
        if (bus.rd_pending !== 4'd0 || bus.rsp_orphan !== 1'b0)
            $display("FAIL reset_state pending %0d orphan %b want 0 0",
                     bus.rd_pending, bus.rsp_orphan);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.rsp_orphan !== 1'b0)
            $display("FAIL reset_orphan_held got %b want 0", bus.rsp_orphan);
        else n_pass++;
    endtask

    task automatic test_rr_writes();
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 4'b0000, 1'b1, 1'b0, '0);
            want = N'(1) << (c % N);
            n_checks++;
            if (bus.req_ready !== want || bus.cmd_data !== e_data)
                $display("FAIL rr_write c%0d ready %b want %b data %h want %h",
                         c, bus.req_ready, want, bus.cmd_data, e_data);
            else n_pass++;
            n_checks++;
            if (bus.rd_pending !== 4'd0)
                $display("FAIL rr_pending c%0d got %0d want 0", c, bus.rd_pending);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_stall();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 4'b0010, 1'b0, 1'b0, '0);
            if (bus.req_ready[1]) pulses++;
            n_checks++;
            if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== e_data)
                $display("FAIL stall_hold c%0d valid %b data %h want 1 %h",
                         c, bus.cmd_valid, bus.cmd_data, e_data);
            else n_pass++;
            tick();
        end
        drive(4'b0010, 4'b0010, 1'b1, 1'b0, '0);
        if (bus.req_ready[1]) pulses++;
        n_checks++;
        if (bus.req_ready !== 4'b0010)
            $display("FAIL stall_accept got %b want 0010", bus.req_ready);
        else n_pass++;
        tick();
        drive(4'b1111, 4'b0000, 1'b1, 1'b0, '0);
        n_checks++;
        if (pulses != 1 || bus.req_ready !== 4'b0100)
            $display("FAIL stall_ptr pulses %0d ready %b want 1 0100",
                     pulses, bus.req_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_full();
        logic [DW-1:0] d;
        do_reset();
        for (int c = 0; c < MAXO; c++) begin
            drive(4'b0100, 4'b0100, 1'b1, 1'b0, '0);
            n_checks++;
            if (bus.req_ready !== 4'b0100)
                $display("FAIL full_fill c%0d got %b want 0100", c, bus.req_ready);
            else n_pass++;
            tick();
        end
        drive(4'b0100, 4'b0100, 1'b1, 1'b0, '0);
        n_checks++;
        if (bus.cmd_valid !== 1'b0 || bus.req_ready !== 4'b0000 ||
            bus.rd_pending !== 4'd8)
            $display("FAIL full_block valid %b ready %b pending %0d want 0 0000 8",
                     bus.cmd_valid, bus.req_ready, bus.rd_pending);
        else n_pass++;
        tick();
        drive(4'b0101, 4'b0100, 1'b1, 1'b0, '0);
        n_checks++;
        if (bus.req_ready !== 4'b0001)
            $display("FAIL full_write got %b want 0001", bus.req_ready);
        else n_pass++;
        tick();
        d = {$urandom, $urandom};
        drive(4'b0010, 4'b0010, 1'b1, 1'b1, d);
        n_checks++;
        if (bus.req_ready !== 4'b0000 || bus.rd_valid !== 4'b0100 ||
            bus.rd_data !== d)
            $display("FAIL full_pop ready %b rdv %b data %h want 0000 0100 %h",
                     bus.req_ready, bus.rd_valid, bus.rd_data, d);
        else n_pass++;
        tick();
        drive(4'b0010, 4'b0010, 1'b1, 1'b0, '0);
        n_checks++;
        if (bus.rd_pending !== 4'd7 || bus.req_ready !== 4'b0010)
            $display("FAIL full_refill pending %0d ready %b want 7 0010",
                     bus.rd_pending, bus.req_ready);
        else n_pass++;
        tick();
        drive('0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if (bus.rd_pending !== 4'd8)
            $display("FAIL full_final pending %0d want 8", bus.rd_pending);
        else n_pass++;
        tick();
    endtask

    task automatic test_order();
        int ids [3] = '{3, 0, 2};
        logic [DW-1:0] d;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            drive(N'(1) << ids[j], N'(1) << ids[j], 1'b1, 1'b0, '0);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            d = {$urandom, $urandom};
            drive('0, '0, 1'b1, 1'b1, d);
            n_checks++;
            if (bus.rd_valid !== (N'(1) << ids[j]) || bus.rd_data !== d)
                $display("FAIL order_rsp%0d rdv %b data %h want %b %h",
                         j, bus.rd_valid, bus.rd_data, N'(1) << ids[j], d);
            else n_pass++;
            tick();
        end
        drive('0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if (bus.rd_pending !== 4'd0 || bus.rsp_orphan !== 1'b0)
            $display("FAIL order_drain pending %0d orphan %b want 0 0",
                     bus.rd_pending, bus.rsp_orphan);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            drive(4'b0010, 4'b0010, 1'b1, 1'b0, '0);
            tick();
        end
        drive('0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if (bus.rd_pending !== 4'd2)
            $display("FAIL mid_pending got %0d want 2", bus.rd_pending);
        else n_pass++;
        do_reset();
        d = {$urandom, $urandom};
        drive('0, '0, 1'b1, 1'b1, d);
        n_checks++;
        if (bus.rd_valid !== 4'b0000)
            $display("FAIL mid_rdv got %b want 0000", bus.rd_valid);
        else n_pass++;
        tick();
        drive('0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if (bus.rsp_orphan !== 1'b1 || bus.rd_pending !== 4'd0)
            $display("FAIL mid_orphan orphan %b pending %0d want 1 0",
                     bus.rsp_orphan, bus.rd_pending);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0]  v;
        logic [N-1:0]  rd;
        logic          cr;
        logic          rv;
        logic [DW-1:0] d;
        int            bad;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v  = N'($urandom);
            rd = N'($urandom);
            cr = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 3) == 0);
            d  = {$urandom, $urandom};
            drive(v, rd, cr, rv, d);
            bad = 0;
            if (bus.cmd_valid !== e_valid || bus.cmd_data !== e_data) bad++;
            if (bus.req_ready !== e_ready) bad++;
            if (bus.rd_valid !== e_rdv) bad++;
            if (rv && bus.rd_data !== d) bad++;
            if (bus.rd_pending !== PW'(m_q.size())) bad++;
            if (bus.rsp_orphan !== m_orphan) bad++;
            n_checks++;
            if (bad != 0)
                $display("FAIL rand c%0d valid %b/%b ready %b/%b rdv %b/%b pend %0d/%0d orph %b/%b",
                         c, bus.cmd_valid, e_valid, bus.req_ready, e_ready,
                         bus.rd_valid, e_rdv, bus.rd_pending, m_q.size(),
                         bus.rsp_orphan, m_orphan);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.req_data  = '0;
        bus.req_valid = '0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        @(negedge clk);
        test_reset();
        test_rr_writes();
        test_stall();
        test_full();
        test_order();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
